// File: rtl/regfile_arbiter_if.sv
// Requester and register-file signal bundle for regfile_arbiter; slave = arbiter view, master = driver view.
// req0_lock exists only when RF_ARB_LOCK_EN is defined.
interface regfile_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic             req0_valid;
    logic             req0_wr;
    logic [ADDR-1:0]  req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_rdata;
    logic             req0_rvalid;
`ifdef RF_ARB_LOCK_EN
    logic             req0_lock;
`endif
    logic             req1_valid;
    logic             req1_wr;
    logic [ADDR-1:0]  req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_rdata;
    logic             req1_rvalid;
    logic             rf_WrEn;
    logic             rf_RdEn;
    logic [ADDR-1:0]  rf_Address;
    logic [WIDTH-1:0] rf_WrData;
    logic [WIDTH-1:0] rf_RdData;
    logic             rf_RdData_VLD;
    logic             busy;
    logic             err_timeout;

    modport slave (
`ifdef RF_ARB_LOCK_EN
        input  req0_lock,
`endif
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        output req0_ready, req0_rdata, req0_rvalid,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        output req1_ready, req1_rdata, req1_rvalid,
        output rf_WrEn, rf_RdEn, rf_Address, rf_WrData,
        input  rf_RdData, rf_RdData_VLD,
        output busy, err_timeout
    );

    modport master (
`ifdef RF_ARB_LOCK_EN
        output req0_lock,
`endif
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req0_ready, req0_rdata, req0_rvalid,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        input  req1_ready, req1_rdata, req1_rvalid,
        input  rf_WrEn, rf_RdEn, rf_Address, rf_WrData,
        output rf_RdData, rf_RdData_VLD,
        input  busy, err_timeout
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin two-requester sequencer for the shared register file; write strobe at T+1, read response at T+2+VLD delay.
// Ready only in IDLE (one access in flight); RF_ARB_LOCK_EN adds req0_lock to exclude req1 while locked.
module regfile_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ADDR    = 4,
    parameter int TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    regfile_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wren_q, wren_d;
    logic             rden_q, rden_d;
    logic             rvalid_q, rvalid_d;
    logic             tout_q, tout_d;
    logic             gnt0, gnt1, sel_wr, locked;

`ifdef RF_ARB_LOCK_EN
    logic lock_q, lock_d;
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Tie goes to the requester that did not win last; a held lock shuts req1 out entirely.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_q || locked);
            gnt1 = bus.req1_valid && !locked && (!bus.req0_valid || !last_grant_q);
        end
    end

    assign sel_wr = gnt1 ? bus.req1_wr : bus.req0_wr;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        wren_d       = 1'b0;
        rden_d       = 1'b0;
        rvalid_d     = 1'b0;
        tout_d       = 1'b0;
`ifdef RF_ARB_LOCK_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    addr_d       = gnt1 ? bus.req1_addr  : bus.req0_addr;
                    wdata_d      = gnt1 ? bus.req1_wdata : bus.req0_wdata;
`ifdef RF_ARB_LOCK_EN
                    if (gnt0) lock_d = bus.req0_lock;
`endif
                    if (sel_wr) begin
                        state_d = WRITE;
                        wren_d  = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                        rden_d  = 1'b1;
                    end
                end
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Data arriving on the last wait cycle still wins over the timeout.
                if (bus.rf_RdData_VLD) begin
                    rdata_d  = bus.rf_RdData;
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    tout_d   = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_RESP:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wren_q       <= 1'b0;
            rden_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            tout_q       <= 1'b0;
`ifdef RF_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            wren_q       <= wren_d;
            rden_q       <= rden_d;
            rvalid_q     <= rvalid_d;
            tout_q       <= tout_d;
`ifdef RF_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.req0_rvalid = rvalid_q && !owner_q;
    assign bus.req1_rvalid = rvalid_q && owner_q;
    assign bus.req0_rdata  = (rvalid_q && !owner_q) ? rdata_q : '0;
    assign bus.req1_rdata  = (rvalid_q && owner_q)  ? rdata_q : '0;
    assign bus.rf_WrEn     = wren_q;
    assign bus.rf_RdEn     = rden_q;
    assign bus.rf_Address  = addr_q;
    assign bus.rf_WrData   = wdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.err_timeout = tout_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed steps then random commands against a transaction-level model.
// Define RF_ARB_LOCK_EN for both files to exercise the lock step.
module tb_regfile_arbiter;
    localparam int WIDTH   = 8;
    localparam int ADDR    = 4;
    localparam int TIMEOUT = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    regfile_arbiter_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();
    regfile_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Register-file stand-in: rf_delay cycles after the RdEn cycle it returns data; 0 means never.
    logic [WIDTH-1:0] rf_mem [16] = '{default: '0};
    int               rf_delay = 1;
    int               rf_lat = 0;
    logic [ADDR-1:0]  rf_raddr = '0;
    always @(negedge CLK) begin
        bus.rf_RdData_VLD = 1'b0;
        bus.rf_RdData     = '0;
        if (bus.rf_WrEn === 1'b1) rf_mem[bus.rf_Address] = bus.rf_WrData;
        if (bus.rf_RdEn === 1'b1) begin
            rf_lat   = rf_delay;
            rf_raddr = bus.rf_Address;
        end else if (rf_lat > 0) begin
            rf_lat--;
            if (rf_lat == 0) begin
                bus.rf_RdData_VLD = 1'b1;
                bus.rf_RdData     = rf_mem[rf_raddr];
            end
        end
    end

    logic [WIDTH-1:0] exp_mem [16] = '{default: '0};
    int   model_last = 1;
    logic model_lock = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        chk({tag, "_wren"},   32'(bus.rf_WrEn), 32'd0);
        chk({tag, "_rden"},   32'(bus.rf_RdEn), 32'd0);
        chk({tag, "_rvalid"}, 32'({bus.req0_rvalid, bus.req1_rvalid}), 32'd0);
        chk({tag, "_rdata"},  32'({bus.req0_rdata, bus.req1_rdata}), 32'd0);
        chk({tag, "_tout"},   32'(bus.err_timeout), 32'd0);
    endtask

    // One command opportunity from the current IDLE cycle through to the response.
    task automatic do_cmd(input logic v0, input logic v1, input logic wr0, input logic wr1,
                          input logic [ADDR-1:0] a0, input logic [ADDR-1:0] a1,
                          input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input int dly, input logic lk, output int g);
        logic             wr, to;
        logic [ADDR-1:0]  a;
        logic [WIDTH-1:0] d, exp_rd;
        int               n;
        bus.req0_valid = v0; bus.req0_wr = wr0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_wr = wr1; bus.req1_addr = a1; bus.req1_wdata = d1;
`ifdef RF_ARB_LOCK_EN
        bus.req0_lock = lk;
`endif
        rf_delay = dly;
        #1;
        if (v0 && v1)  g = (model_lock || model_last == 1) ? 0 : 1;
        else if (v0)   g = 0;
        else if (v1)   g = model_lock ? -1 : 1;
        else           g = -1;
        chk("ready0", 32'(bus.req0_ready), 32'(g == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(g == 1));
        if (g < 0) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            tick();
            return;
        end
        model_last = g;
`ifdef RF_ARB_LOCK_EN
        if (g == 0) model_lock = lk;
`endif
        wr = (g == 1) ? wr1 : wr0;
        a  = (g == 1) ? a1  : a0;
        d  = (g == 1) ? d1  : d0;
        tick();
        if (g == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        #1;
        chk("busy_strobe", 32'(bus.busy), 32'd1);
        chk("ready_busy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("strobes", 32'({bus.rf_WrEn, bus.rf_RdEn}), wr ? 32'd2 : 32'd1);
        chk("rf_addr", 32'(bus.rf_Address), 32'(a));
        if (wr) begin
            chk("rf_wdata", 32'(bus.rf_WrData), 32'(d));
            exp_mem[a] = d;
            tick();
            chk("wr_done_busy", 32'(bus.busy), 32'd0);
            chk("wr_done_wren", 32'(bus.rf_WrEn), 32'd0);
            return;
        end
        to     = !(dly >= 1 && dly <= TIMEOUT);
        n      = to ? TIMEOUT : dly;
        exp_rd = to ? '0 : exp_mem[a];
        for (int k = 0; k < n; k++) begin
            tick();
            chk("wait_quiet", 32'({bus.req0_rvalid, bus.req1_rvalid, bus.err_timeout,
                                   bus.rf_WrEn, bus.rf_RdEn, bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        tick();
        chk("rvalid0", 32'(bus.req0_rvalid), 32'(g == 0));
        chk("rvalid1", 32'(bus.req1_rvalid), 32'(g == 1));
        chk("rdata_own", 32'((g == 0) ? bus.req0_rdata : bus.req1_rdata), 32'(exp_rd));
        chk("rdata_other", 32'((g == 0) ? bus.req1_rdata : bus.req0_rdata), 32'd0);
        chk("err_timeout", 32'(bus.err_timeout), 32'(to));
        tick();
        chk_idle_outputs("rd_done");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        RST = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
`ifdef RF_ARB_LOCK_EN
        bus.req0_lock = 1'b0;
`endif
        tick();
        tick();
        RST = 1'b0;
        chk_idle_outputs("reset");
        chk("reset_addr", 32'(bus.rf_Address), 32'd0);
        chk("reset_wdata", 32'(bus.rf_WrData), 32'd0);
        chk("reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

        // Basic write then read-back of the same register.
        do_cmd(1, 0, 1, 0, 4'd4, 4'd0, 8'hA5, 8'h00, 1, 0, g);
        do_cmd(1, 0, 0, 0, 4'd4, 4'd0, 8'h00, 8'h00, 1, 0, g);
        // Register file never answers: timeout path.
        do_cmd(1, 0, 0, 0, 4'd9, 4'd0, 8'h00, 8'h00, 0, 0, g);
        // Data on the final allowed wait cycle still counts.
        do_cmd(1, 0, 0, 0, 4'd4, 4'd0, 8'h00, 8'h00, TIMEOUT, 0, g);
        // Both requesters contending: grants alternate.
        for (int i = 0; i < 6; i++)
            do_cmd(1, 1, 0, 1, 4'd2, 4'd7, 8'h00, 8'h3C, 1, 0, g);
        // Address extremes from requester 1.
        do_cmd(0, 1, 0, 1, 4'd0, 4'd15, 8'h00, 8'hFF, 1, 0, g);
        do_cmd(0, 1, 0, 0, 4'd0, 4'd15, 8'h00, 8'h00, 2, 0, g);
        do_cmd(0, 1, 0, 1, 4'd0, 4'd3, 8'h00, 8'h5A, 1, 0, g);

        // Reset while waiting for read data: no response may follow.
        rf_delay = 0;
        bus.req0_valid = 1'b1; bus.req0_wr = 1'b0; bus.req0_addr = 4'd5;
        #1;
        chk("rst_hs_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("rst_in_wait_busy", 32'(bus.busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_addr", 32'(bus.rf_Address), 32'd0);
        model_last = 1;
        model_lock = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_no_resp", 32'({bus.req0_rvalid, bus.req1_rvalid, bus.err_timeout, bus.busy}), 32'd0);
        end
        do_cmd(0, 1, 0, 0, 4'd0, 4'd3, 8'h00, 8'h00, 1, 0, g);

`ifdef RF_ARB_LOCK_EN
        do_cmd(1, 0, 1, 0, 4'd1, 4'd0, 8'h11, 8'h00, 1, 1, g);
        do_cmd(0, 1, 0, 0, 4'd0, 4'd6, 8'h00, 8'h00, 1, 0, g);
        do_cmd(1, 1, 0, 1, 4'd1, 4'd6, 8'h00, 8'h66, 1, 1, g);
        do_cmd(1, 1, 1, 1, 4'd2, 4'd6, 8'h22, 8'h67, 1, 1, g);
        do_cmd(1, 1, 0, 1, 4'd2, 4'd6, 8'h00, 8'h68, 1, 0, g);
        do_cmd(1, 1, 0, 1, 4'd2, 4'd6, 8'h00, 8'h69, 1, 0, g);
`endif

        // Random traffic against the transaction model.
        for (int i = 0; i < 120; i++) begin
            int dly;
            dly = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            do_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                   dly, ($urandom_range(0, 3) == 0), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
